// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search controller.
// Optional build macro: SAR_EARLY_EXIT_EN (see sar_search.sv).
package sar_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } sar_state_t;

    // Default operand width, which is also the number of search steps
    localparam int SAR_DEFAULT_WIDTH = 16;

    // MSB-only mask for the default width; the first trial bit of a search
    localparam logic [SAR_DEFAULT_WIDTH-1:0] SAR_DEFAULT_MSB_MASK =
        SAR_DEFAULT_WIDTH'(1) << (SAR_DEFAULT_WIDTH - 1);

endpackage

// File: rtl/sar_search_mask_shifter.sv
// One-hot trial-bit register for the search controller.
// load puts the MSB in place, shift walks it one bit towards the LSB,
// clear empties it (clear wins over load, load wins over shift).
// last is high while the LSB is the bit under trial.
module sar_mask_shifter
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic             clear,
    output logic [WIDTH-1:0] mask,
    output logic             last
);

    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] mask_reg;

    // One-hot mask register: clear, load MSB, or shift right
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= '0;
        end else if (clear) begin
            mask_reg <= '0;
        end else if (load) begin
            mask_reg <= MSB_MASK;
        end else if (shift) begin
            mask_reg <= mask_reg >> 1;
        end
    end

    assign mask = mask_reg;
    assign last = (mask_reg == WIDTH'(1));

endmodule

// File: rtl/sar_search.sv
// Successive-approximation search controller. Drives trial values on Probe
// into an external magnitude comparator (unknown on its A side) and builds
// Result one bit per cycle, MSB first, from the Greater/Equal verdicts.
// Optional build macro SAR_EARLY_EXIT_EN: an Equal verdict ends the search
// immediately; otherwise every search takes exactly WIDTH steps.
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Greater,
    input  logic             Equal,
    output logic [WIDTH-1:0] Probe,
    output logic [WIDTH-1:0] Result,
    output logic             Busy,
    output logic             Done
);

    sar_state_t       state_reg;
    sar_state_t       state_next;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] mask;
    logic             mask_last;
    logic             mask_load;
    logic             mask_shift;
    logic             mask_clear;
    logic             accept;
    logic             finish;

    sar_mask_shifter #(
        .WIDTH (WIDTH)
    ) u_mask (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mask_load),
        .shift (mask_shift),
        .clear (mask_clear),
        .mask  (mask),
        .last  (mask_last)
    );

    // Trial value: the bit under test is OR'ed in only while searching.
    // Mask bits are never already set in Result, so no carry is possible.
    assign Probe = (state_reg == SEARCH) ? (result_reg | mask) : result_reg;

    // A verdict of "greater or equal" keeps the trial bit; both flags high
    // is treated as Equal, which keeps the bit as well.
    assign accept = Greater | Equal;

`ifdef SAR_EARLY_EXIT_EN
    // Equal means Probe already matches the unknown: lower bits stay zero
    assign finish = mask_last | Equal;
`else
    assign finish = mask_last;
`endif

    // Next-state and datapath control
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        mask_load   = 1'b0;
        mask_shift  = 1'b0;
        mask_clear  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (Start) begin
                    state_next  = SEARCH;
                    result_next = '0;
                    mask_load   = 1'b1;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            SEARCH: begin
                mask_shift = 1'b1;
                if (accept) begin
                    result_next = Probe;
                end
                if (finish) begin
                    state_next = DONE;
                    mask_clear = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                mask_clear = 1'b1;
            end
        endcase
    end

    // State and result registers; reset aborts any search silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
        end
    end

    assign Result = result_reg;
    assign Busy   = (state_reg == SEARCH);
    assign Done   = (state_reg == DONE);

endmodule
